ifft_8_point_seq: RTL and testbench

//  Inverse 8-point FFT engine: return path of the 8-point FFT datapath.

---
 rtl/ifft_8_point_seq.sv | 191 +++++++++++++++++++
 tb/tb_ifft_8_point_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_8_point_seq.sv
// 8-point inverse FFT: loads 8 bins bit-reversed, runs 12 in-place radix-2 DIT
// butterflies with +j twiddles and per-stage halving, then streams x[0..7].
module ifft_8_point_seq #(
   parameter int N      = 4,
   parameter int C_ISQ2 = 181
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2**N-1:0] in_r,
   input  logic [2**N-1:0] in_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2**N-1:0] out_r,
   output logic [2**N-1:0] out_i,
   output logic            out_last,
   output logic            busy
);
   localparam int W  = 2**N;
   localparam int WE = W + 2;   // twiddle sums/products
   localparam int WS = W + 3;   // butterfly sum before halving
   localparam int WP = WE + 10; // constant multiply

   localparam logic signed [WS-1:0] SAT_MAX = WS'((2**(W-1)) - 1);
   localparam logic signed [WS-1:0] SAT_MIN = WS'(-(2**(W-1)));
   localparam logic signed [WP-1:0] C_FIX   = WP'(C_ISQ2);

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_UNLOAD} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [2:0]            n_q, n_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [W-1:0]          out_r_q, out_r_d, out_i_q, out_i_d;
   logic signed [W-1:0]   mem_r_q [8];
   logic signed [W-1:0]   mem_i_q [8];

   logic                  wr_load, wr_bf;
   logic [2:0]            pa, pb;
   logic [1:0]            tw;
   logic signed [WE-1:0]  ar, ai, br, bi, wr, wi;
   logic signed [W-1:0]   sum_r, sum_i, dif_r, dif_i;

   function automatic logic signed [WE-1:0] mul_c(input logic signed [WE-1:0] v);
      logic signed [WP-1:0] prod;
      prod = WP'(v) * C_FIX;
      return WE'(prod >>> 8);
   endfunction

   function automatic logic signed [W-1:0] sat(input logic signed [WS-1:0] v);
      if (v > SAT_MAX) return W'(SAT_MAX);
      if (v < SAT_MIN) return W'(SAT_MIN);
      return W'(v);
   endfunction

   // Butterfly schedule: cnt_q[3:2] is the stage, cnt_q[1:0] the butterfly in it.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      pa = '0;
      pb = '0;
      tw = '0;
      case (cnt_q[3:2])
         2'd0: begin
            pa = {cnt_q[1:0], 1'b0};
            pb = {cnt_q[1:0], 1'b1};
         end
         2'd1: begin
            pa = {cnt_q[1], 1'b0, cnt_q[0]};
            pb = {cnt_q[1], 1'b1, cnt_q[0]};
            tw = {cnt_q[0], 1'b0};
         end
         default: begin
            pa = {1'b0, cnt_q[1:0]};
            pb = {1'b1, cnt_q[1:0]};
            tw = cnt_q[1:0];
         end
      endcase

      ar = WE'(mem_r_q[pa]);
      ai = WE'(mem_i_q[pa]);
      br = WE'(mem_r_q[pb]);
      bi = WE'(mem_i_q[pb]);
      case (tw)
         2'd0:    begin wr = br;                wi = bi;             end
         2'd1:    begin wr = mul_c(br - bi);    wi = mul_c(br + bi); end
         2'd2:    begin wr = -bi;               wi = br;             end
         default: begin wr = mul_c(-br - bi);   wi = mul_c(br - bi); end
      endcase
      sum_r = sat((WS'(ar) + WS'(wr)) >>> 1);
      sum_i = sat((WS'(ai) + WS'(wi)) >>> 1);
      dif_r = sat((WS'(ar) - WS'(wr)) >>> 1);
      dif_i = sat((WS'(ai) - WS'(wi)) >>> 1);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_r_d     = out_r_q;
      out_i_d     = out_i_q;
      wr_load     = 1'b0;
      wr_bf       = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               wr_load = 1'b1;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            wr_bf = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd11) begin
               cnt_d   = '0;
               n_d     = '0;
               state_d = S_UNLOAD;
            end
         end
         default: begin
            // First UNLOAD cycle registers x[0]; later ones advance on handshake.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_r_d     = mem_r_q[n_q];
               out_i_d     = mem_i_q[n_q];
               out_last_d  = (n_q == 3'd7);
            end else if (out_ready) begin
               if (n_q == 3'd7) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = S_LOAD;
               end else begin
                  n_d        = n_q + 3'd1;
                  out_r_d    = mem_r_q[n_q + 3'd1];
                  out_i_d    = mem_i_q[n_q + 3'd1];
                  out_last_d = (n_q == 3'd6);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         state_q     <= S_LOAD;
         cnt_q       <= '0;
         n_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_r_q     <= '0;
         out_i_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_r_q     <= out_r_d;
         out_i_q     <= out_i_d;
      end
   end

   // NOTE: the register file has no reset; a full frame is always written before it is read.
   always_ff @(posedge clk) begin
      if (wr_load) begin
         mem_r_q[{cnt_q[0], cnt_q[1], cnt_q[2]}] <= in_r;
         mem_i_q[{cnt_q[0], cnt_q[1], cnt_q[2]}] <= in_i;
      end
      if (wr_bf) begin
         mem_r_q[pa] <= sum_r;
         mem_i_q[pa] <= sum_i;
         mem_r_q[pb] <= dif_r;
         mem_i_q[pb] <= dif_i;
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q != S_LOAD);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_r     = out_r_q;
   assign out_i     = out_i_q;
endmodule

// File: tb/tb_ifft_8_point_seq.sv
// Scoreboard bench for ifft_8_point_seq: a stage-by-stage IFFT model fills a queue,
// and a negedge monitor checks samples, ordering, stall stability and latency.
module tb_ifft_8_point_seq;
   localparam int W = 16;

   typedef int arr8_t [8];
   typedef struct {
      int r;
      int i;
      bit last;
      int acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] in_r = '0;
   logic [W-1:0] in_i = '0;
   logic         in_ready, out_valid, out_last, busy;
   logic [W-1:0] out_r, out_i;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];

   ifft_8_point_seq #(.N(4), .C_ISQ2(181)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic int sat_m(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int mulc_m(input int v);
      return (v * 181) >>> 8;
   endfunction

   // Inverse DIT FFT: bit-reversed load, then per stage every pair with twiddle e^(+j*2*pi*t/8).
   function automatic void ifft_model(input arr8_t xr, input arr8_t xi,
                                      output arr8_t yr, output arr8_t yi);
      int mr[8], mi[8];
      for (int k = 0; k < 8; k++) begin
         int rk;
         rk = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
         mr[rk] = xr[k];
         mi[rk] = xi[k];
      end
      for (int s = 0; s < 3; s++) begin
         int h;
         h = 1 << s;
         for (int p = 0; p < 8; p++) begin
            if ((p % (2 * h)) < h) begin
               int t, b_r, b_i, w_r, w_i, a_r, a_i;
               t   = (p % h) * (4 >> s);
               a_r = mr[p];     a_i = mi[p];
               b_r = mr[p + h]; b_i = mi[p + h];
               case (t)
                  0:       begin w_r = b_r;                w_i = b_i;               end
                  1:       begin w_r = mulc_m(b_r - b_i);  w_i = mulc_m(b_r + b_i); end
                  2:       begin w_r = -b_i;               w_i = b_r;               end
                  default: begin w_r = mulc_m(-b_r - b_i); w_i = mulc_m(b_r - b_i); end
               endcase
               mr[p]     = sat_m((a_r + w_r) >>> 1);
               mi[p]     = sat_m((a_i + w_i) >>> 1);
               mr[p + h] = sat_m((a_r - w_r) >>> 1);
               mi[p + h] = sat_m((a_i - w_i) >>> 1);
            end
         end
      end
      yr = mr;
      yi = mi;
   endfunction

   task automatic send_frame(input arr8_t xr, input arr8_t xi, input bit gaps);
      arr8_t yr, yi;
      int    k, guard;
      ifft_model(xr, xi, yr, yi);
      k = 0;
      guard = 0;
      while (k < 8) begin
         @(posedge clk);
         #1;
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_r = W'(xr[k]);
            in_i = W'(xi[k]);
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            k++;
            if (k == 8) begin
               for (int n = 0; n < 8; n++) begin
                  exp_t e;
                  e.r = yr[n]; e.i = yi[n]; e.last = (n == 7); e.acc = cyc + 1;
                  exp_q.push_back(e);
               end
            end
         end
         guard++;
         if (guard > 2000) begin
            check("input_timeout", 1'b0, $sformatf("accepted %0d of 8 bins", k));
            break;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Monitor
   bit           prev_valid = 0, prev_stall = 0, after_last = 0;
   logic [W-1:0] prev_r, prev_i;
   logic         prev_l;

   always @(negedge clk) begin
      if (!rst) begin
         prev_valid = 0;
         prev_stall = 0;
         after_last = 0;
      end else begin
         if (after_last) begin
            check("ready_after_last", in_ready && !out_valid,
                  $sformatf("in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid));
            after_last = 0;
         end
         check("busy_vs_ready", busy != in_ready,
               $sformatf("busy=%0b in_ready=%0b", busy, in_ready));
         if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0)
               check("unexpected_valid", 1'b0, "out_valid with empty scoreboard");
            else
               check("latency", (cyc - exp_q[0].acc) == 13,
                     $sformatf("got %0d cycles want 13", cyc - exp_q[0].acc));
         end
         if (prev_stall)
            check("stall_stable", out_valid && out_r == prev_r && out_i == prev_i && out_last == prev_l,
                  $sformatf("got v=%0b (%0d,%0d,l%0b) want (%0d,%0d,l%0b)", out_valid,
                            $signed(out_r), $signed(out_i), out_last,
                            $signed(prev_r), $signed(prev_i), prev_l));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_sample", 1'b0, "handshake with empty scoreboard");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sample", $signed(out_r) == e.r && $signed(out_i) == e.i && out_last == e.last,
                     $sformatf("got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)",
                               $signed(out_r), $signed(out_i), out_last, e.r, e.i, e.last));
               check("no_input_during_unload", !in_ready, "in_ready high during UNLOAD");
            end
            if (out_last) after_last = 1;
         end
         prev_valid = out_valid;
         prev_stall = out_valid && !out_ready;
         prev_r = out_r;
         prev_i = out_i;
         prev_l = out_last;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      arr8_t xr, xi;
      logic signed [W-1:0] v;

      #1;
      check("reset_outputs", in_ready && !out_valid && !out_last && !busy && out_r == 0 && out_i == 0,
            $sformatf("in_ready=%0b out_valid=%0b out_last=%0b busy=%0b out=(%0d,%0d)",
                      in_ready, out_valid, out_last, busy, out_r, out_i));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      xr = '{default: 0}; xi = '{default: 0}; xr[0] = 8192;
      send_frame(xr, xi, 0);
      xr = '{default: 0}; xr[1] = 8192;
      send_frame(xr, xi, 0);
      xr = '{default: 32767}; xi = '{default: 32767};
      send_frame(xr, xi, 0);

      rand_ready = 1'b1;
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 8; k++) begin
            v = W'($urandom); xr[k] = v;
            v = W'($urandom); xi[k] = v;
         end
         send_frame(xr, xi, 1);
      end

      // Reset five cycles into CALC, then an impulse frame.
      xr = '{default: 0}; xi = '{default: 0}; xr[0] = 8192;
      send_frame(xr, xi, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      #1;
      check("reset_mid_calc", in_ready && !out_valid && !busy && !out_last,
            $sformatf("in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("after_reset_release", in_ready && !out_valid,
            $sformatf("in_ready=%0b out_valid=%0b", in_ready, out_valid));
      send_frame(xr, xi, 0);

      for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
      check("drain", exp_q.size() == 0, $sformatf("%0d samples never delivered", exp_q.size()));
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
